song_autoplay: RTL and testbench
================================

SONG_AUTOPLAY -- requirements
Module: song_autoplay

Interface
REQ-001 Parameter SONG_TABLE, 108 bits, default 0: 4 songs x 9 notes x 3-bit key index; note n of song s occupies bits [(s*9+n)*3 +: 3].
REQ-002 Parameter NOTE_ON_TICKS, default 4: trigger ticks each key is held high; legal range 1..255.
REQ-003 Parameter GAP_TICKS, default 1: trigger ticks of silence after each note; legal range 1..255.
REQ-004 Parameter LOOP, default 0: 1 = continue to the next song after note 8; 0 = stop after note 8.
REQ-005 clk_in  input  1: single clock; all logic on its rising edge.
REQ-006 rst_in  input  1: synchronous, active-high reset.
REQ-007 trigger  input  1: timing tick; advances only the duration counting.
REQ-008 start  input  1: begin playback of song_select; sampled every cycle, not gated by trigger.
REQ-009 stop  input  1: abort playback; sampled every cycle.
REQ-010 song_select  input  2: song index captured on an accepted start.
REQ-011 keys_out  output  8: one-hot key drive, same encoding as the key inputs of the guided-play counter; all zero when silent.
REQ-012 counter  output  4: index of the current note, 0..8.
REQ-013 song_address  output  2: index of the song being played.
REQ-014 busy  output  1: high whenever state is not IDLE.
REQ-015 done  output  1: single-cycle pulse when a non-looping song completes.

Function
REQ-016 State machine states: IDLE, NOTE_ON, GAP; an 8-bit tick counter tick_cnt counts trigger ticks within a state.
REQ-017 Outputs:
 - all outputs are registered.
 - keys_out is nonzero only in NOTE_ON.
 - keys_out = 1 << SONG_TABLE note(song_address, counter).
REQ-018 IDLE with start=1 and stop=0, on the next edge:
 - song_address <= song_select, counter <= 0, tick_cnt <= 0.
 - keys_out <= one-hot of note 0; state <= NOTE_ON; busy <= 1.
REQ-019 NOTE_ON:
 - each cycle with trigger=1 increments tick_cnt.
 - on a trigger cycle with tick_cnt == NOTE_ON_TICKS-1: keys_out <= 0, tick_cnt <= 0, state <= GAP.
REQ-020 GAP:
 - each cycle with trigger=1 increments tick_cnt.
 - on a trigger cycle with tick_cnt == GAP_TICKS-1, exactly one of REQ-021..023 applies.
REQ-021 counter < 8: counter <= counter+1; keys_out <= one-hot of the new note; tick_cnt <= 0; state <= NOTE_ON.
REQ-022 counter == 8 and LOOP=1:
 - counter <= 0.
 - song_address <= song_address+1, wrapping 3 -> 0.
 - keys_out <= one-hot of note 0 of the new song; state <= NOTE_ON.
REQ-023 counter == 8 and LOOP=0: state <= IDLE, busy <= 0, done <= 1 for exactly one cycle; counter and song_address hold their values.
REQ-024 stop=1 in any state, on the next edge: state <= IDLE, keys_out <= 0, busy <= 0, tick_cnt <= 0; done stays 0; counter and song_address hold their values.
REQ-025 stop and start asserted in the same cycle: stop wins; the block stays in or enters IDLE.
REQ-026 start while busy is ignored; playback continues unchanged.
REQ-027 Cycles with trigger=0 change no state, counter, or output, except for start and stop handling.
REQ-028 Each note lasts exactly NOTE_ON_TICKS trigger ticks high, then GAP_TICKS trigger ticks low, so the same key played twice in a row produces a fresh rising edge.
REQ-029 Latency: keys_out goes high on the edge after start is accepted, with no trigger required.

Reset
REQ-030 While rst_in=1 on an edge:
 - state <= IDLE.
 - keys_out, counter, song_address, busy, done, tick_cnt <= 0.
REQ-031 Reset asserted mid-song aborts playback identically to REQ-030 and takes precedence over start and stop.

Verification
REQ-032 SONG_TABLE song 0 = notes 0..7,0; NOTE_ON_TICKS=4; GAP_TICKS=1; LOOP=0; trigger every cycle; start with song_select=0 -> keys_out 01,02,04,...,80,01.
 - Each key is held 4 cycles, followed by 1 zero cycle.
 - After the final gap: done pulses once, busy=0, counter=8.
REQ-033 Same setup with LOOP=1 and song_select=3 -> after note 8, song_address=0, counter=0, keys_out = note 0 of song 0; busy stays 1.
REQ-034 Assert stop during note 4 -> next cycle keys_out=0, busy=0, done=0, counter=4; a later start restarts at counter=0.
REQ-035 trigger every 3rd cycle with NOTE_ON_TICKS=2 -> each key is held 4..6 clocks; no state advance on non-trigger cycles.
REQ-036 start and stop in the same cycle from IDLE -> busy stays 0; start during NOTE_ON -> ignored.
REQ-037 rst_in pulsed during GAP of note 5 -> all outputs 0 on the next cycle, including keys_out.

Source files
------------

// File: rtl/song_autoplay.sv
// Plays one of four stored 9-note songs on a one-hot key bus, holding each key for
// NOTE_ON_TICKS trigger ticks followed by GAP_TICKS ticks of silence.
module song_autoplay #(
    parameter logic [107:0] SONG_TABLE    = '0,
    parameter int           NOTE_ON_TICKS = 4,
    parameter int           GAP_TICKS     = 1,
    parameter bit           LOOP          = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trigger,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] song_select,
    output logic [7:0] keys_out,
    output logic [3:0] counter,
    output logic [1:0] song_address,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NOTE_ON = 2'd1,
        GAP     = 2'd2
    } state_t;

    localparam logic [7:0] ON_LAST   = 8'(NOTE_ON_TICKS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);
    localparam logic [3:0] LAST_NOTE = 4'd8;

    state_t     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [7:0] keys_d;
    logic [3:0] counter_d;
    logic [1:0] song_d;
    logic       done_d;

    // One-hot key for a given note of a given song, taken from the packed table.
    function automatic logic [7:0] key_onehot(input logic [1:0] song, input logic [3:0] note);
        int         base;
        logic [2:0] idx;
        base = (int'(song) * 9 + int'(note)) * 3;
        idx  = SONG_TABLE[base +: 3];
        return 8'(1) << idx;
    endfunction

    // start and stop are level inputs sampled on every edge; stop always wins,
    // and start is only honoured from IDLE, so there is no handshake to complete.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        keys_d    = keys_out;
        counter_d = counter;
        song_d    = song_address;
        done_d    = 1'b0;

        if (stop) begin
            state_d = IDLE;
            keys_d  = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        song_d    = song_select;
                        counter_d = '0;
                        tick_d    = '0;
                        keys_d    = key_onehot(song_select, 4'd0);
                        state_d   = NOTE_ON;
                    end
                end
                NOTE_ON: begin
                    if (trigger) begin
                        if (tick_q == ON_LAST) begin
                            keys_d  = '0;
                            tick_d  = '0;
                            state_d = GAP;
                        end else begin
                            tick_d = tick_q + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (trigger) begin
                        if (tick_q == GAP_LAST) begin
                            tick_d = '0;
                            if (counter < LAST_NOTE) begin
                                counter_d = counter + 4'd1;
                                keys_d    = key_onehot(song_address, counter + 4'd1);
                                state_d   = NOTE_ON;
                            end else if (LOOP) begin
                                counter_d = '0;
                                song_d    = song_address + 2'd1;
                                keys_d    = key_onehot(song_address + 2'd1, 4'd0);
                                state_d   = NOTE_ON;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    keys_d  = '0;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            keys_out     <= '0;
            counter      <= '0;
            song_address <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            keys_out     <= keys_d;
            counter      <= counter_d;
            song_address <= song_d;
            busy         <= (state_d != IDLE);
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_song_autoplay.sv
// Directed bench for song_autoplay: one-shot play, loop wrap, stop/start races,
// reset mid-song and sparse trigger timing, each against hand-derived expectations.
module tb_song_autoplay;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stop;
    logic [1:0] sel;
    logic       trig_a, trig_b, trig_c;

    logic [7:0] keys_a, keys_b, keys_c;
    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] addr_a, addr_b, addr_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;

    // Song 0 = 0..7,0 ; song 3 = 7..0,7 ; songs 1 and 2 all zero.
    function automatic logic [107:0] build_table();
        logic [107:0] t;
        t = '0;
        for (int n = 0; n < 9; n++) begin
            t[n*3 +: 3]        = (n == 8) ? 3'd0 : 3'(n);
            t[(27+n)*3 +: 3]   = (n == 8) ? 3'd7 : 3'(7 - n);
        end
        return t;
    endfunction

    localparam logic [107:0] TABLE = build_table();

    function automatic int exp_note0(input int n);
        return (n == 8) ? 0 : n;
    endfunction

    function automatic int exp_note3(input int n);
        return (n == 8) ? 7 : 7 - n;
    endfunction

    song_autoplay #(.SONG_TABLE(TABLE), .NOTE_ON_TICKS(4), .GAP_TICKS(1), .LOOP(1'b0)) dut_a (
        .clk_in(clk), .rst_in(rst), .trigger(trig_a), .start(start), .stop(stop),
        .song_select(sel), .keys_out(keys_a), .counter(cnt_a), .song_address(addr_a),
        .busy(busy_a), .done(done_a));

    song_autoplay #(.SONG_TABLE(TABLE), .NOTE_ON_TICKS(4), .GAP_TICKS(1), .LOOP(1'b1)) dut_b (
        .clk_in(clk), .rst_in(rst), .trigger(trig_b), .start(start), .stop(stop),
        .song_select(sel), .keys_out(keys_b), .counter(cnt_b), .song_address(addr_b),
        .busy(busy_b), .done(done_b));

    song_autoplay #(.SONG_TABLE(TABLE), .NOTE_ON_TICKS(2), .GAP_TICKS(1), .LOOP(1'b0)) dut_c (
        .clk_in(clk), .rst_in(rst), .trigger(trig_c), .start(start), .stop(stop),
        .song_select(sel), .keys_out(keys_c), .counter(cnt_c), .song_address(addr_c),
        .busy(busy_c), .done(done_c));

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        trig_a = 1'b0;
        trig_b = 1'b0;
        trig_c = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic start_song(input logic [1:0] s);
        sel   = s;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; sel = 2'd0;
        trig_a = 1'b0; trig_b = 1'b0; trig_c = 1'b0;

        // Reset state
        do_reset();
        check("rst_keys",  32'(keys_a), 32'h0);
        check("rst_cnt",   32'(cnt_a),  32'h0);
        check("rst_addr",  32'(addr_a), 32'h0);
        check("rst_busy",  32'(busy_a), 32'h0);
        check("rst_done",  32'(done_a), 32'h0);
        check("rst_keys_b", 32'(keys_b), 32'h0);

        // Key rises on the edge after start, with no trigger; idle triggers hold everything
        start_song(2'd0);
        check("lat_keys", 32'(keys_a), 32'h01);
        check("lat_busy", 32'(busy_a), 32'h1);
        check("lat_cnt",  32'(cnt_a),  32'h0);
        step(6);
        check("hold_keys", 32'(keys_a), 32'h01);
        check("hold_cnt",  32'(cnt_a),  32'h0);

        // Full one-shot song: 4 cycles high, 1 cycle gap per note
        trig_a = 1'b1;
        for (int n = 0; n < 9; n++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("play_keys_n%0d_c%0d", n, c), 32'(keys_a), 32'(1) << exp_note0(n));
                check($sformatf("play_cnt_n%0d", n), 32'(cnt_a), 32'(n));
                step(1);
            end
            check($sformatf("gap_keys_n%0d", n), 32'(keys_a), 32'h0);
            check($sformatf("gap_busy_n%0d", n), 32'(busy_a), 32'h1);
            step(1);
        end
        check("end_done", 32'(done_a), 32'h1);
        check("end_busy", 32'(busy_a), 32'h0);
        check("end_cnt",  32'(cnt_a),  32'h8);
        check("end_keys", 32'(keys_a), 32'h0);
        step(1);
        check("end_done_drop", 32'(done_a), 32'h0);
        check("end_cnt_hold",  32'(cnt_a),  32'h8);

        // Stop during note 4
        do_reset();
        start_song(2'd0);
        trig_a = 1'b1;
        step(20);
        check("pre_stop_cnt",  32'(cnt_a),  32'h4);
        check("pre_stop_keys", 32'(keys_a), 32'h10);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_keys", 32'(keys_a), 32'h0);
        check("stop_busy", 32'(busy_a), 32'h0);
        check("stop_done", 32'(done_a), 32'h0);
        check("stop_cnt",  32'(cnt_a),  32'h4);
        step(3);
        check("stop_idle_busy", 32'(busy_a), 32'h0);
        check("stop_idle_cnt",  32'(cnt_a),  32'h4);
        start_song(2'd0);
        check("restart_cnt",  32'(cnt_a),  32'h0);
        check("restart_keys", 32'(keys_a), 32'h01);
        check("restart_busy", 32'(busy_a), 32'h1);

        // Start while busy is ignored
        start_song(2'd3);
        check("busy_start_addr", 32'(addr_a), 32'h0);
        check("busy_start_cnt",  32'(cnt_a),  32'h0);
        check("busy_start_keys", 32'(keys_a), 32'h01);

        // Stop and start together: stop wins, from busy and from idle
        stop = 1'b1; start = 1'b1;
        step(1);
        check("race_busy_from_play", 32'(busy_a), 32'h0);
        check("race_keys_from_play", 32'(keys_a), 32'h0);
        step(1);
        check("race_busy_from_idle", 32'(busy_a), 32'h0);
        check("race_keys_from_idle", 32'(keys_a), 32'h0);
        stop = 1'b0; start = 1'b0;

        // Reset during the gap of note 5, with start also high
        do_reset();
        start_song(2'd0);
        trig_a = 1'b1;
        step(29);
        check("gap5_keys", 32'(keys_a), 32'h0);
        check("gap5_busy", 32'(busy_a), 32'h1);
        check("gap5_cnt",  32'(cnt_a),  32'h5);
        rst = 1'b1; start = 1'b1;
        step(1);
        rst = 1'b0; start = 1'b0;
        check("midrst_keys", 32'(keys_a), 32'h0);
        check("midrst_cnt",  32'(cnt_a),  32'h0);
        check("midrst_addr", 32'(addr_a), 32'h0);
        check("midrst_busy", 32'(busy_a), 32'h0);
        check("midrst_done", 32'(done_a), 32'h0);

        // Looping song 3 wraps to song 0
        do_reset();
        start_song(2'd3);
        trig_b = 1'b1;
        for (int n = 0; n < 9; n++) begin
            check($sformatf("loop_keys_n%0d", n), 32'(keys_b), 32'(1) << exp_note3(n));
            check($sformatf("loop_cnt_n%0d", n),  32'(cnt_b),  32'(n));
            check($sformatf("loop_addr_n%0d", n), 32'(addr_b), 32'h3);
            step(5);
        end
        check("wrap_addr", 32'(addr_b), 32'h0);
        check("wrap_cnt",  32'(cnt_b),  32'h0);
        check("wrap_keys", 32'(keys_b), 32'h01);
        check("wrap_busy", 32'(busy_b), 32'h1);
        check("wrap_done", 32'(done_b), 32'h0);

        // Trigger every third cycle with a 2-tick note: 6 clocks high, 3 low
        do_reset();
        start_song(2'd0);
        check("sparse_s0", 32'(keys_c), 32'h01);
        for (int k = 0; k < 27; k++) begin
            int s;
            trig_c = (k % 3 == 2);
            step(1);
            s = k + 1;
            check($sformatf("sparse_keys_s%0d", s), 32'(keys_c),
                  (s % 9 < 6) ? (32'(1) << exp_note0(s / 9)) : 32'h0);
            check($sformatf("sparse_cnt_s%0d", s), 32'(cnt_c), 32'(s / 9));
        end
        trig_c = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
